// File: rtl/iq_pkg.sv
// Shared types and default sizing for the instruction queue.
package iq_pkg;

    localparam int unsigned IQ_DEPTH   = 8;
    localparam int unsigned IQ_INSTR_W = 32;
    localparam int unsigned IQ_PC_W    = 64;

    typedef struct packed {
        logic [IQ_INSTR_W-1:0] instr;
        logic [IQ_PC_W-1:0]    pc;
    } iq_entry_t;

endpackage

// File: rtl/iq_ptr.sv
// Queue pointer: increment with explicit wrap at DEPTH-1, so non-power-of-two depths work.
module iq_ptr
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int unsigned PW = $clog2(DEPTH);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction FIFO with flush; define IQ_BYPASS_EN for empty-queue
// bypass (fetch presented to decode in the same cycle).
module instr_queue
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH   = IQ_DEPTH,
    parameter int unsigned INSTR_W = IQ_INSTR_W,
    parameter int unsigned PC_W    = IQ_PC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid_i,
    input  logic [INSTR_W-1:0]       fetch_instr_i,
    input  logic [PC_W-1:0]          fetch_pc_i,
    output logic                     fetch_ready_o,
    output logic                     dec_valid_o,
    output logic [INSTR_W-1:0]       dec_instr_o,
    output logic [PC_W-1:0]          dec_pc_o,
    input  logic                     dec_ready_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [PC_W-1:0]    mem_pc    [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          rd_en;

    assign empty = (count_o == '0);

`ifdef IQ_BYPASS_EN
    assign bypass = empty & ~flush_i & ~reset & fetch_valid_i;
`else
    assign bypass = 1'b0;
`endif

    assign fetch_ready_o = (count_o != CW'(DEPTH)) & ~flush_i;
    assign push          = fetch_valid_i & fetch_ready_o;
    assign pop           = dec_valid_o & dec_ready_i;

    // A bypassed entry consumed in the same cycle never touches storage.
    assign wr_en = push & ~(bypass & dec_ready_i);
    assign rd_en = pop & ~bypass;

    always_comb begin
        dec_valid_o = ~empty & ~flush_i;
        dec_instr_o = '0;
        dec_pc_o    = '0;
        if (!empty) begin
            dec_instr_o = mem_instr[rd_ptr];
            dec_pc_o    = mem_pc[rd_ptr];
        end else if (bypass) begin
            dec_valid_o = 1'b1;
            dec_instr_o = fetch_instr_i;
            dec_pc_o    = fetch_pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_instr[wr_ptr] <= fetch_instr_i;
            mem_pc[wr_ptr]    <= fetch_pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            count_o <= '0;
        end else if (wr_en && !rd_en) begin
            count_o <= count_o + CW'(1);
        end else if (!wr_en && rd_en) begin
            count_o <= count_o - CW'(1);
        end
    end

    iq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush_i),
        .inc   (wr_en),
        .ptr   (wr_ptr)
    );

    iq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush_i),
        .inc   (rd_en),
        .ptr   (rd_ptr)
    );

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (default DEPTH=8); follows IQ_BYPASS_EN if defined.
module tb_instr_queue;

`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid_i;
    logic [31:0] fetch_instr_i;
    logic [63:0] fetch_pc_i;
    logic        fetch_ready_o;
    logic        dec_valid_o;
    logic [31:0] dec_instr_o;
    logic [63:0] dec_pc_o;
    logic        dec_ready_i;
    logic        flush_i;
    logic [3:0]  count_o;

    int n_checks = 0;
    int n_fail   = 0;

    instr_queue #(.DEPTH(8), .INSTR_W(32), .PC_W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid_i (fetch_valid_i),
        .fetch_instr_i (fetch_instr_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_ready_o (fetch_ready_o),
        .dec_valid_o   (dec_valid_o),
        .dec_instr_o   (dec_instr_o),
        .dec_pc_o      (dec_pc_o),
        .dec_ready_i   (dec_ready_i),
        .flush_i       (flush_i),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic cyc_start();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_valid_i = 1'b0; dec_ready_i = 1'b0; flush_i = 1'b0;
        fetch_instr_i = 32'hDEAD_BEEF; fetch_pc_i = 64'h1234;
        repeat (2) @(posedge clk);
        cyc_start(); #1;
        n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        n_checks++; if (fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", fetch_ready_o); end
        n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dec_valid_o); end
        n_checks++; if (dec_pc_o !== 64'h0 || dec_instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got pc %0h instr %0h expected 0 0", dec_pc_o, dec_instr_o); end
        reset = 1'b0;
        cyc_start(); #1;
        n_checks++; if (dec_valid_o !== 1'b0 || fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset: got valid %b ready %b expected 0 1", dec_valid_o, fetch_ready_o); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            cyc_start();
            fetch_valid_i = 1'b1; dec_ready_i = 1'b0;
            fetch_pc_i = 64'(i * 4); fetch_instr_i = 32'h8B00_0000 + 32'(i);
            #1;
            n_checks++; if (fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, fetch_ready_o); end
            if (i == 0) begin
                n_checks++; if (dec_valid_o !== BYP) begin n_fail++; $display("FAIL fill_first_valid: got %b expected %b", dec_valid_o, BYP); end
            end
            if (i == 1) begin
                n_checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 64'h0) begin n_fail++; $display("FAIL push_latency: got valid %b pc %0h expected 1 0", dec_valid_o, dec_pc_o); end
            end
        end
        cyc_start();
        fetch_pc_i = 64'h20; fetch_instr_i = 32'h8B00_0008;
        #1;
        n_checks++; if (count_o !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", count_o); end
        n_checks++; if (fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", fetch_ready_o); end
        // Full queue must refuse a push even if decode pops this cycle.
        dec_ready_i = 1'b1;
        #1;
        n_checks++; if (fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready_pop: got %b expected 0", fetch_ready_o); end
        dec_ready_i = 1'b0;
        cyc_start(); #1;
        n_checks++; if (count_o !== 4'd8) begin n_fail++; $display("FAIL ninth_push: got %0d expected 8", count_o); end
        fetch_valid_i = 1'b0;
    endtask

    task automatic test_drain();
        fetch_valid_i = 1'b0; dec_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if (dec_valid_o !== 1'b1 || dec_pc_o !== 64'(i * 4) || dec_instr_o !== 32'h8B00_0000 + 32'(i) || count_o !== 4'(8 - i)) begin
                n_fail++;
                $display("FAIL drain[%0d]: got valid %b pc %0h instr %0h count %0d expected 1 %0h %0h %0d",
                         i, dec_valid_o, dec_pc_o, dec_instr_o, count_o, i * 4, 32'h8B00_0000 + 32'(i), 8 - i);
            end
            cyc_start();
        end
        #1;
        n_checks++; if (count_o !== 4'd0 || dec_valid_o !== 1'b0 || dec_pc_o !== 64'h0) begin n_fail++; $display("FAIL drain_empty: got count %0d valid %b pc %0h expected 0 0 0", count_o, dec_valid_o, dec_pc_o); end
        dec_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        dec_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc_start();
            fetch_valid_i = 1'b1; fetch_pc_i = 64'h100 + 64'(i * 4); fetch_instr_i = 32'hA000 + 32'(i);
        end
        for (int k = 0; k < 20; k++) begin
            cyc_start();
            fetch_valid_i = 1'b1; dec_ready_i = 1'b1;
            fetch_pc_i = 64'h10C + 64'(k * 4); fetch_instr_i = 32'hA003 + 32'(k);
            #1;
            n_checks++;
            if (count_o !== 4'd3 || dec_pc_o !== 64'h100 + 64'(k * 4) || dec_instr_o !== 32'hA000 + 32'(k)) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got count %0d pc %0h instr %0h expected 3 %0h %0h",
                         k, count_o, dec_pc_o, dec_instr_o, 64'h100 + 64'(k * 4), 32'hA000 + 32'(k));
            end
        end
        cyc_start();
        fetch_valid_i = 1'b0;
        for (int k = 20; k < 23; k++) begin
            #1;
            n_checks++; if (dec_pc_o !== 64'h100 + 64'(k * 4)) begin n_fail++; $display("FAIL b2b_tail[%0d]: got %0h expected %0h", k, dec_pc_o, 64'h100 + 64'(k * 4)); end
            cyc_start();
        end
        #1;
        n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d expected 0", count_o); end
        dec_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            cyc_start();
            fetch_valid_i = 1'b1; dec_ready_i = 1'b0;
            fetch_pc_i = 64'h200 + 64'(i * 4); fetch_instr_i = 32'hB000 + 32'(i);
        end
        cyc_start();
        flush_i = 1'b1; fetch_valid_i = 1'b1; dec_ready_i = 1'b1;
        fetch_pc_i = 64'h300; fetch_instr_i = 32'hC000;
        #1;
        n_checks++; if (count_o !== 4'd5) begin n_fail++; $display("FAIL preflush_count: got %0d expected 5", count_o); end
        n_checks++; if (fetch_ready_o !== 1'b0 || dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_cycle: got ready %b valid %b expected 0 0", fetch_ready_o, dec_valid_o); end
        cyc_start();
        flush_i = 1'b0; fetch_valid_i = 1'b0; dec_ready_i = 1'b0;
        #1;
        n_checks++; if (count_o !== 4'd0 || dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_flush: got count %0d valid %b expected 0 0", count_o, dec_valid_o); end
        fetch_valid_i = 1'b1; fetch_pc_i = 64'h400; fetch_instr_i = 32'hD000;
        cyc_start();
        fetch_valid_i = 1'b0;
        #1;
        n_checks++; if (count_o !== 4'd1 || dec_pc_o !== 64'h400 || dec_instr_o !== 32'hD000) begin n_fail++; $display("FAIL flush_after: got count %0d pc %0h instr %0h expected 1 400 d000", count_o, dec_pc_o, dec_instr_o); end
        dec_ready_i = 1'b1;
        cyc_start();
        dec_ready_i = 1'b0;
        #1;
        n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL flush_drain: got %0d expected 0", count_o); end
    endtask

    task automatic test_bypass();
        cyc_start();
        fetch_valid_i = 1'b1; dec_ready_i = 1'b1;
        fetch_pc_i = 64'h40; fetch_instr_i = 32'h0000_0013;
        #1;
        n_checks++; if (dec_valid_o !== BYP) begin n_fail++; $display("FAIL byp_valid: got %b expected %b", dec_valid_o, BYP); end
        n_checks++; if (dec_pc_o !== (BYP ? 64'h40 : 64'h0)) begin n_fail++; $display("FAIL byp_pc: got %0h expected %0h", dec_pc_o, BYP ? 64'h40 : 64'h0); end
        cyc_start();
        fetch_valid_i = 1'b0;
        #1;
        n_checks++; if (count_o !== (BYP ? 4'd0 : 4'd1)) begin n_fail++; $display("FAIL byp_count: got %0d expected %0d", count_o, BYP ? 0 : 1); end
        n_checks++; if (dec_valid_o !== !BYP || dec_pc_o !== (BYP ? 64'h0 : 64'h40)) begin n_fail++; $display("FAIL byp_next: got valid %b pc %0h expected %b %0h", dec_valid_o, dec_pc_o, !BYP, BYP ? 64'h0 : 64'h40); end
        cyc_start();
        dec_ready_i = 1'b0;
        #1;
        n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL byp_final: got %0d expected 0", count_o); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 8, sets the number of queue entries; legal range 2..32, any integer value.
REQ-002 Parameter INSTR_W, default 32, sets the instruction word width.
REQ-003 Parameter PC_W, default 64, sets the PC width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fetch_valid_i  in  1  fetch offers an instruction this cycle.
REQ-007 fetch_instr_i  in  INSTR_W  fetched instruction word.
REQ-008 fetch_pc_i  in  PC_W  PC of the fetched instruction.
REQ-009 fetch_ready_o  out  1  queue accepts a push this cycle.
REQ-010 dec_valid_o  out  1  head entry is presented to the decode/control stage.
REQ-011 dec_instr_o  out  INSTR_W  head instruction word.
REQ-012 dec_pc_o  out  PC_W  head PC.
REQ-013 dec_ready_i  in  1  decode consumes the head this cycle.
REQ-014 flush_i  in  1  branch redirect; discard all entries.
REQ-015 count_o  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 A push SHALL occur when fetch_valid_i & fetch_ready_o; a pop SHALL occur when dec_valid_o & dec_ready_i.
REQ-017 fetch_ready_o SHALL be (count_o != DEPTH) & ~flush_i, with no combinational dependence on dec_ready_i; a full queue SHALL NOT accept a push even in a pop cycle.
REQ-018 dec_valid_o SHALL be (count_o != 0) & ~flush_i; dec_instr_o/dec_pc_o SHALL show the head entry when count_o != 0 and all-zero otherwise.
REQ-019 Entries SHALL leave in push order (FIFO); push-to-dec_valid_o latency SHALL be exactly 1 cycle.
REQ-020 Simultaneous push and pop with 0 < count_o < DEPTH SHALL advance both pointers and leave count_o unchanged.
REQ-021 Read and write pointers SHALL wrap from DEPTH-1 to 0 with explicit compare, valid for non-power-of-two DEPTH.
REQ-022 flush_i high SHALL set count_o and both pointers to 0 on the next edge; any push or pop in that cycle SHALL be discarded.
REQ-023 fetch_valid_i SHALL be ignored while fetch_ready_o is low; payload inputs SHALL be ignored when no push occurs.

Reset
REQ-024 reset SHALL clear count_o and both pointers to 0 on the next edge; storage contents SHALL NOT be cleared.
REQ-025 During and after reset, fetch_ready_o SHALL be 1 (unless flush_i), dec_valid_o 0, dec_instr_o and dec_pc_o 0.
REQ-026 reset SHALL take priority over flush_i, push and pop in the same cycle.

Configuration
REQ-027 Macro IQ_BYPASS_EN SHALL select empty-queue bypass.
REQ-028 With IQ_BYPASS_EN defined: when count_o == 0, ~flush_i and fetch_valid_i, dec_valid_o SHALL be 1 in the same cycle with fetch data on dec_instr_o/dec_pc_o; if dec_ready_i is also 1, the entry SHALL NOT be written and count_o SHALL stay 0.
REQ-029 Without IQ_BYPASS_EN, latency SHALL be as REQ-019 and the fetch inputs SHALL have no combinational path to the dec_* outputs.

Structure
REQ-030 Package iq_pkg SHALL hold the iq_entry_t typedef {instr, pc} and the default DEPTH, INSTR_W and PC_W constants.
REQ-031 Pointer increment-with-wrap SHALL be a sub-module iq_ptr (parameter DEPTH; inputs clk, reset, clr, inc; output ptr), instantiated twice.

Verification
REQ-032 Reset, then push PC 0x0..0x1C with instr 0x8B000000+i, dec_ready_i=0 -> count_o=8, fetch_ready_o=0; a ninth push is ignored.
REQ-033 Drain the full queue with dec_ready_i=1 -> PCs 0x0..0x1C appear in order, one per cycle; count_o reaches 0 and dec_valid_o drops.
REQ-034 With count_o=3, push and pop every cycle for 20 cycles -> count_o stays 3, order is preserved, pointers wrap at least twice.
REQ-035 With count_o=5, assert flush_i together with fetch_valid_i=1 -> fetch_ready_o=0 and dec_valid_o=0 that cycle; count_o=0 on the next cycle; the flushed push never appears.
REQ-036 With IQ_BYPASS_EN defined and the queue empty, push PC 0x40 with dec_ready_i=1 -> dec_valid_o=1 and dec_pc_o=0x40 in the same cycle, count_o stays 0; without the macro, the entry appears on the next cycle.
